// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Holds the program counter, fetches instruction words from instruction
//   memory over a req/ack interface and presents each word to decode on a
//   valid/ready handshake. Jump redirects (j_signal/j_target) retarget the PC
//   and flush any wrong-path word, whether it is still in flight or already
//   presented.
//
// Optional feature macro: PC_WRAP_TRAP_EN
//   defined   : consuming the word at pc = 2^PC_W-1 halts the sequencer and
//               raises trap. Only reset leaves HALT.
//   undefined : pc wraps modulo 2^PC_W, there is no HALT state, trap is 0.
//
// Handshakes:
//   imem  : imem_req/imem_addr are registered and held until a cycle with
//           imem_ack=1. imem_rdata is captured in that cycle. An ack seen
//           while imem_req=0 is ignored.
//   decode: instr/instr_pc are stable while instr_valid=1. A word is consumed
//           in a cycle with instr_valid=1, instr_ready=1 and j_signal=0. A
//           j_signal in that cycle flushes the word instead.
//
// Ports
//   clk, rst (async, active low)
//   start                   begin fetching from IDLE
//   j_signal, j_target      redirect request and target
//   imem_req, imem_addr     fetch request and address
//   imem_ack, imem_rdata    memory acknowledge and data
//   instr, instr_pc         word for decode and its address
//   instr_valid, instr_ready  decode handshake
//   pc                      current fetch PC
//   busy                    not in IDLE
//   trap                    PC wrap trap
//   state_dbg               current FSM state encoding
module pc_fetch_sequencer #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               j_signal,
  input  logic [PC_W-1:0]    j_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               trap,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
`ifdef PC_WRAP_TRAP_EN
    ,
    S_HALT = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               redir_pend_q, redir_pend_d;
  logic [PC_W-1:0]    redir_tgt_q, redir_tgt_d;
`ifdef PC_WRAP_TRAP_EN
  logic               trap_q, trap_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = 1'b0;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
`ifdef PC_WRAP_TRAP_EN
    trap_d       = trap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (req_q) begin
          if (imem_ack) begin
            // req_d stays 0: either we leave REQ or we take the one-cycle
            // gap before re-requesting at the redirect target.
            if (redir_pend_q || j_signal) begin
              pc_d         = j_signal ? j_target : redir_tgt_q;
              redir_pend_d = 1'b0;
            end else begin
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              state_d = S_OUT;
            end
          end else begin
            // Request outstanding: the address must not move, so a redirect
            // is parked until the ack. Latest target wins.
            req_d = 1'b1;
            if (j_signal) begin
              redir_pend_d = 1'b1;
              redir_tgt_d  = j_target;
            end
          end
        end else begin
          // Request-low cycle on entry to REQ: nothing in flight, so a
          // redirect can retarget the PC directly.
          req_d = 1'b1;
          if (j_signal) pc_d = j_target;
        end
      end
      S_OUT: begin
        if (j_signal) begin
          valid_d = 1'b0;
          pc_d    = j_target;
          state_d = S_REQ;
        end else if (instr_ready) begin
          valid_d = 1'b0;
`ifdef PC_WRAP_TRAP_EN
          if (&pc_q) begin
            state_d = S_HALT;
            trap_d  = 1'b1;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_REQ;
          end
`else
          pc_d    = pc_q + PC_W'(1);
          state_d = S_REQ;
`endif
        end
      end
`ifdef PC_WRAP_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      instr_q      <= '0;
      ipc_q        <= '0;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
`ifdef PC_WRAP_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
`ifdef PC_WRAP_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q != S_IDLE);
  assign state_dbg   = state_q;
`ifdef PC_WRAP_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        j_signal = 1'b0;
  logic [7:0]  j_target = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        trap;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .j_signal(j_signal),
    .j_target(j_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .busy(busy), .trap(trap),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'h13};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   imem_req, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_pc"},    pc, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_ipc"},   instr_pc, 0);
    check({tag, "_trap"},  trap, 0);
  endtask

  task automatic drive_idle();
    start = 0; j_signal = 0; j_target = 0;
    imem_ack = 0; imem_rdata = 0; instr_ready = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic        j;
    logic [7:0]  tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [7:0]  e_ipc;
    logic [31:0] e_instr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic j, logic [7:0] tgt, logic ack,
                              logic [31:0] rd, logic rdy, logic e_req,
                              logic [7:0] e_addr, logic e_valid,
                              logic [7:0] e_ipc, logic [31:0] e_instr,
                              logic e_busy);
    vec_t v;
    v.start = st; v.j = j; v.tgt = tgt; v.ack = ack; v.rdata = rd;
    v.ready = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_busy = e_busy;
    return v;
  endfunction

  localparam logic [31:0] W0  = 32'h00A0_0013;
  localparam logic [31:0] W1  = 32'h1111_2222;
  localparam logic [31:0] WJ  = 32'hDEAD_BEEF;
  localparam logic [31:0] W10 = 32'h0010_0093;

  // random-phase model state
  logic [7:0]  next_pc;
  logic        expect_hold;
  logic [31:0] held_instr;
  logic [7:0]  held_pc;
  logic        prev_req, prev_ack;
  logic        halt_exp;
  int          wait_cnt;
  int          delivered;

  initial begin
    // ---- reset ----
    drive_idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1;

    // ---- directed vectors: start/ack latency, stall, flush, parked redirect
    vecs.push_back(mk(1,0,8'h00,0,0,0, 0,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,1,W0,0, 0,8'h00,1,8'h00,W0,1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,8'h00,0,0,0, 0,8'h00,1,8'h00,W0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,1, 0,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h01,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,1,W1,0, 0,8'h00,1,8'h01,W1,1));
    vecs.push_back(mk(0,1,8'h40,0,0,1, 0,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h40,0,8'h00,0,1));
    vecs.push_back(mk(0,1,8'h10,0,0,0, 1,8'h40,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h40,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h40,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,1,WJ,0, 0,8'h00,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,8'h10,0,8'h00,0,1));
    vecs.push_back(mk(0,0,8'h00,1,W10,0, 0,8'h00,1,8'h10,W10,1));
    vecs.push_back(mk(0,0,8'h00,0,0,1, 0,8'h00,0,8'h00,0,1));

    foreach (vecs[k]) begin
      @(negedge clk);
      start = vecs[k].start; j_signal = vecs[k].j; j_target = vecs[k].tgt;
      imem_ack = vecs[k].ack; imem_rdata = vecs[k].rdata;
      instr_ready = vecs[k].ready;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_req", k), imem_req, vecs[k].e_req);
      check($sformatf("vec%0d_valid", k), instr_valid, vecs[k].e_valid);
      check($sformatf("vec%0d_busy", k), busy, vecs[k].e_busy);
      if (vecs[k].e_req)
        check($sformatf("vec%0d_addr", k), imem_addr, vecs[k].e_addr);
      if (vecs[k].e_valid) begin
        check($sformatf("vec%0d_ipc", k), instr_pc, vecs[k].e_ipc);
        check($sformatf("vec%0d_instr", k), instr, vecs[k].e_instr);
      end
    end

    // ---- PC wrap at 0xFF (sequencer is in its request-low cycle) ----
    @(negedge clk);
    drive_idle(); j_signal = 1; j_target = 8'hFF;
    @(posedge clk); #1;
    check("wrap_addr", imem_addr, 8'hFF);
    @(negedge clk);
    drive_idle(); imem_ack = 1; imem_rdata = mem_word(8'hFF);
    @(posedge clk); #1;
    check("wrap_ipc", instr_pc, 8'hFF);
    check("wrap_valid", instr_valid, 1);
    @(negedge clk);
    drive_idle(); instr_ready = 1;
    @(posedge clk); #1;
    check("wrap_valid_drop", instr_valid, 0);
    check("wrap_busy", busy, 1);
`ifdef PC_WRAP_TRAP_EN
    check("wrap_trap", trap, 1);
    check("wrap_req", imem_req, 0);
    check("wrap_pc_hold", pc, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_idle(); start = 1; j_signal = 1; j_target = 8'h33;
      @(posedge clk); #1;
      check("halt_trap", trap, 1);
      check("halt_req", imem_req, 0);
      check("halt_pc", pc, 8'hFF);
    end
    @(negedge clk);
    drive_idle(); rst = 0;
    #1;
    check("halt_reset_trap", trap, 0);
    check("halt_reset_busy", busy, 0);
    @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
`else
    check("wrap_trap", trap, 0);
    check("wrap_pc", pc, 8'h00);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    check("wrap_next_addr", imem_addr, 8'h00);
    @(negedge clk);
`endif

    // ---- reset asserted mid-request, ack arriving during reset ----
    check("midreq_req_before", imem_req, 1);
    drive_idle(); rst = 0; imem_ack = 1; imem_rdata = WJ;
    #1;
    check_reset_values("midreq");
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("late_ack_busy", busy, 0);
    check("late_ack_req", imem_req, 0);
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_pc", pc, 8'h00);

    // ---- randomized run against a transaction-level model ----
    // Model: the next word delivered must come from the latest redirect
    // target seen while busy, else from the consumed word's address + 1.
    next_pc = 8'h00; expect_hold = 0; held_instr = 0; held_pc = 0;
    prev_req = 0; prev_ack = 0; halt_exp = 0; wait_cnt = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (halt_exp) begin
        check("rnd_halt_trap", trap, 1);
        check("rnd_halt_valid", instr_valid, 0);
        check("rnd_halt_req", imem_req, 0);
        break;
      end
      if (expect_hold) begin
        check("rnd_hold_valid", instr_valid, 1);
        check("rnd_hold_instr", instr, held_instr);
        check("rnd_hold_ipc", instr_pc, held_pc);
      end else if (instr_valid) begin
        check("rnd_ipc", instr_pc, next_pc);
        check("rnd_instr", instr, mem_word(next_pc));
        held_instr = mem_word(next_pc);
        held_pc = next_pc;
        delivered++;
      end
      if (prev_req && !prev_ack) check("rnd_req_held", imem_req, 1);
      check("rnd_trap", trap, 0);

      start       = (cyc == 0);
      j_signal    = ($urandom_range(0, 9) == 0);
      j_target    = 8'($urandom_range(0, 255));
      instr_ready = ($urandom_range(0, 2) != 0);
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack = 1; imem_rdata = mem_word(imem_addr);
        end else begin
          imem_ack = 0; imem_rdata = 32'hBAD0_BAD0; wait_cnt--;
        end
      end else begin
        imem_ack = 0; wait_cnt = $urandom_range(0, 3);
      end

      expect_hold = 0;
      if (busy) begin
        if (j_signal) begin
          next_pc = j_target;
        end else if (instr_valid && instr_ready) begin
`ifdef PC_WRAP_TRAP_EN
          if (held_pc == 8'hFF) halt_exp = 1;
`endif
          next_pc = held_pc + 8'd1;
        end else if (instr_valid) begin
          expect_hold = 1;
        end
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
    end
    check("rnd_delivered_any", (delivered != 0), 1);

    drive_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
